// File: rtl/alu_accum_unit.sv
// Accumulator-style ALU with A/B registers, registered result and flags.
// Every operation takes at least one EXEC cycle. SHL and SHR with a shift
// amount of 2 or more continue one bit per cycle in SHIFT, on a working copy
// of A.
module alu_accum_unit #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] din,
  input  logic             ld_b,
  output logic [WIDTH-1:0] y,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             done,
  output logic [WIDTH-1:0] a_led,
  output logic [WIDTH-1:0] b_led
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       s_op;
  logic [WIDTH-1:0] s_a, s_b, s_din, wk;
  logic             s_ldb;
  logic [SW-1:0]    cnt;

  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic [WIDTH-1:0] src, st_r, res;
  logic             st_c, rc, rv, gt, fin;
  logic [WIDTH:0]   wide;

  assign op_ready = (state == IDLE);
  assign a_led    = a;
  assign b_led    = b;
  assign shamt    = s_b[SW-1:0];
  assign is_shift = (s_op == 4'h2) || (s_op == 4'h3);

  // One shift step: the first step works on the snapshot of A, later steps on the working copy.
  always_comb begin
    src = (state == EXEC) ? s_a : wk;
    if (s_op == 4'h2) begin
      st_r = {src[WIDTH-2:0], 1'b0};
      st_c = src[WIDTH-1];
    end else begin
      st_r = {1'b0, src[WIDTH-1:1]};
      st_c = src[0];
    end
  end

  // Result and carry/overflow for the snapshotted operation.
  always_comb begin
    res  = '0;
    rc   = 1'b0;
    rv   = 1'b0;
    wide = '0;
    gt   = SIGNED_CMP ? ($signed(s_a) > $signed(s_b)) : (s_a > s_b);
    case (s_op)
      4'h0: begin
        wide = {1'b0, s_a} + {1'b0, s_b};
        res  = wide[WIDTH-1:0];
        rc   = wide[WIDTH];
        rv   = (s_a[WIDTH-1] == s_b[WIDTH-1]) && (res[WIDTH-1] != s_a[WIDTH-1]);
      end
      4'h1: begin
        wide = {1'b0, s_a} - {1'b0, s_b};
        res  = wide[WIDTH-1:0];
        rc   = wide[WIDTH];
        rv   = (s_a[WIDTH-1] != s_b[WIDTH-1]) && (res[WIDTH-1] != s_a[WIDTH-1]);
      end
      4'h2, 4'h3: begin
        // shamt 0 is a plain pass-through of A
        if (shamt == '0) res = s_a;
        else begin
          res = st_r;
          rc  = st_c;
        end
      end
      4'h4: res = (s_a == s_b) ? '0 : (gt ? ONE : '1);
      4'h5: res = s_a & s_b;
      4'h6: res = s_a | s_b;
      4'h7: res = s_a ^ s_b;
      4'h8: res = ~(s_a & s_b);
      4'h9: res = ~(s_a | s_b);
      4'hA: res = ~(s_a ^ s_b);
      4'hB: res = ~s_a;
      4'hC: begin
        res = '0 - s_a;
        rv  = (s_a == MSB_ONLY);
      end
      default: ;
    endcase
  end

  // Completing edge: EXEC unless a multi-bit shift is pending, or the last SHIFT step.
  assign fin = ((state == EXEC) && !(is_shift && (shamt > SW'(1)))) ||
               ((state == SHIFT) && (cnt == SW'(1)));

  // Control FSM, register file and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      y      <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      done   <= 1'b0;
      s_op   <= '0;
      s_a    <= '0;
      s_b    <= '0;
      s_din  <= '0;
      s_ldb  <= 1'b0;
      wk     <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          s_op  <= opcode;
          s_a   <= a;
          s_b   <= b;
          s_din <= din;
          s_ldb <= ld_b;
          state <= EXEC;
        end
        EXEC: if (!fin) begin
          wk    <= st_r;
          cnt   <= shamt - SW'(1);
          state <= SHIFT;
        end
        SHIFT: begin
          wk  <= st_r;
          cnt <= cnt - SW'(1);
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        done  <= 1'b1;
        state <= IDLE;
        case (s_op)
          4'hD: a <= y;
          4'hE: begin
            a <= s_b;
            b <= s_a;
          end
          4'hF: if (s_ldb) b <= s_din; else a <= s_din;
          default: begin
            y      <= res;
            flag_z <= (res == '0);
            flag_n <= res[WIDTH-1];
            flag_c <= rc;
            flag_v <= rv;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_accum_unit.sv
// Directed bench for alu_accum_unit (WIDTH=8): an unsigned-compare instance
// plus a signed-compare instance driven by the same inputs.
module tb_alu_accum_unit;
  logic       clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, ld_b = 1'b0;
  logic [3:0] opcode = '0;
  logic [7:0] din = '0;
  logic [7:0] y, a_led, b_led, y_s, a_led_s, b_led_s;
  logic       fz, fn, fc, fv, done, op_ready;
  logic       fz_s, fn_s, fc_s, fv_s, done_s, op_ready_s;

  int checks = 0, errors = 0;
  int lat, busy, done_seen;
  logic a_hold, watch;
  logic [7:0] a0;

  alu_accum_unit #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .din(din), .ld_b(ld_b), .y(y),
    .flag_z(fz), .flag_n(fn), .flag_c(fc), .flag_v(fv),
    .done(done), .a_led(a_led), .b_led(b_led));

  alu_accum_unit #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready_s),
    .opcode(opcode), .din(din), .ld_b(ld_b), .y(y_s),
    .flag_z(fz_s), .flag_n(fn_s), .flag_c(fc_s), .flag_v(fv_s),
    .done(done_s), .a_led(a_led_s), .b_led(b_led_s));

  always #5 clk = ~clk;

  // count done pulses while the reset-abort scenario is being watched
  always @(negedge clk) if (watch && done) done_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] d, input logic lb);
    @(negedge clk);
    opcode = op; din = d; ld_b = lb; op_valid = 1'b1;
    a0 = a_led;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_done();
    lat = 0; busy = 0; a_hold = 1'b1;
    while (!done && lat < 40) begin
      if (!op_ready) busy++;
      if (a_led !== a0) a_hold = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    if (!done) chk("timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run(input logic [3:0] op, input logic [7:0] d, input logic lb);
    issue(op, d, lb);
    wait_done();
  endtask

  logic [3:0] lops [7] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
  logic [7:0] lexp [7] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F};

  initial begin
    watch = 1'b0; done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y, 8'h00);
    chk("rst_flags", {fz, fn, fc, fv}, 4'h0);
    chk("rst_ab", {a_led, b_led}, 16'h0000);
    chk("rst_done_ready", {done, op_ready}, 2'b01);
    @(negedge clk) rst_n = 1'b1;

    // ADD with signed overflow
    run(4'hF, 8'h7F, 1'b0);
    run(4'hF, 8'h01, 1'b1);
    chk("load_ab", {a_led, b_led}, 16'h7F01);
    run(4'h0, 8'h00, 1'b0);
    chk("add_y", y, 8'h80);
    chk("add_flags", {fz, fn, fc, fv}, 4'b0101);
    chk("add_lat", lat, 1);

    // SUB borrow, NEG of most-negative value
    run(4'hF, 8'h00, 1'b0);
    run(4'h1, 8'h00, 1'b0);
    chk("sub_y", y, 8'hFF);
    chk("sub_flags", {fz, fn, fc, fv}, 4'b0110);
    run(4'hF, 8'h80, 1'b0);
    run(4'hC, 8'h00, 1'b0);
    chk("neg_y", y, 8'h80);
    chk("neg_flags", {fz, fn, fc, fv}, 4'b0101);

    // SHL by 3: multi-cycle, A visible unchanged
    run(4'hF, 8'h81, 1'b0);
    run(4'hF, 8'h03, 1'b1);
    run(4'h2, 8'h00, 1'b0);
    chk("shl_y", y, 8'h08);
    chk("shl_flags", {fz, fn, fc, fv}, 4'b0000);
    chk("shl_lat", lat, 3);
    chk("shl_busy", busy, 3);
    chk("shl_ahold", {31'd0, a_hold}, 32'd1);
    chk("shl_ready_done", {op_ready, a_led}, 9'h181);

    // CMP unsigned and signed
    run(4'hF, 8'h05, 1'b0);
    run(4'hF, 8'h09, 1'b1);
    run(4'h4, 8'h00, 1'b0);
    chk("cmp_lt", y, 8'hFF);
    run(4'hF, 8'h09, 1'b0);
    run(4'h4, 8'h00, 1'b0);
    chk("cmp_eq", {y, fz}, 9'h001);
    run(4'hF, 8'h05, 1'b1);
    run(4'h4, 8'h00, 1'b0);
    chk("cmp_gt", y, 8'h01);
    run(4'hF, 8'hFF, 1'b0);
    run(4'hF, 8'h01, 1'b1);
    run(4'h4, 8'h00, 1'b0);
    chk("cmpu_ff", y, 8'h01);
    chk("cmps_ff", y_s, 8'hFF);

    // SWP leaves y/flags, then ADD and STO
    run(4'hF, 8'h12, 1'b0);
    run(4'hF, 8'h34, 1'b1);
    run(4'hE, 8'h00, 1'b0);
    chk("swp_ab", {a_led, b_led}, 16'h3412);
    chk("swp_yflags", {y, fz, fn, fc, fv}, 12'h010);
    run(4'h0, 8'h00, 1'b0);
    chk("add2_y", y, 8'h46);
    run(4'hD, 8'h00, 1'b0);
    chk("sto_a", {a_led, y}, 16'h4646);

    // SHR boundaries: shamt 0 and shamt 2 with final carry
    run(4'hF, 8'h00, 1'b1);
    run(4'h3, 8'h00, 1'b0);
    chk("shr0", {y, fc}, 9'h08C);
    chk("shr0_lat", lat, 1);
    run(4'hF, 8'h06, 1'b0);
    run(4'hF, 8'h02, 1'b1);
    run(4'h3, 8'h00, 1'b0);
    chk("shr2_y", y, 8'h01);
    chk("shr2_flags", {fz, fn, fc, fv}, 4'b0010);
    chk("shr2_lat", lat, 2);

    // bitwise ops on A=F0 B=3C
    run(4'hF, 8'hF0, 1'b0);
    run(4'hF, 8'h3C, 1'b1);
    for (int i = 0; i < 7; i++) begin
      run(lops[i], 8'h00, 1'b0);
      chk($sformatf("logic_op%0h", lops[i]), y, lexp[i]);
    end

    // reset in the middle of a long SHR aborts it
    run(4'hF, 8'h07, 1'b1);
    issue(4'h3, 8'h00, 1'b0);
    watch = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort_in_rst", {y, a_led, b_led, fz, fn, fc, fv, done}, 29'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_outs", {y, a_led, b_led, fz, fn, fc, fv, done}, 29'd0);
    chk("abort_ready", {31'd0, op_ready}, 32'd1);
    chk("abort_nodone", done_seen, 0);
    watch = 1'b0;
    run(4'hF, 8'h2A, 1'b0);
    chk("post_rst_load", a_led, 8'h2A);
    chk("post_rst_lat", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
